// File: rtl/memory_stage.sv
// Memory stage of a single-issue pipeline: word RAM with one-cycle load latency,
// access fault detection, and saturating load/store counters.
module memory_stage #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0] in_store_data,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_wr_en,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    output logic             out_valid,
    output logic [4:0]       out_rd,
    output logic             out_reg_wr_en,
    output logic [WIDTH-1:0] out_data,
    output logic             mem_err,
    output logic             err_sticky,
    output logic [15:0]      load_count,
    output logic [15:0]      store_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    logic [ADDR_WIDTH-1:0] index;
    logic                  fault;
    logic                  load_ok;
    logic                  store_ok;
    logic                  mem_we;

    logic             out_valid_q, out_valid_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic             out_reg_wr_en_q, out_reg_wr_en_d;
    logic [WIDTH-1:0] pass_data_q, pass_data_d;
    logic             load_sel_q, load_sel_d;
    logic             mem_err_q, mem_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [15:0]      load_count_q, load_count_d;
    logic [15:0]      store_count_q, store_count_d;

    always_comb begin
        index    = in_addr[ADDR_WIDTH+1:2];
        fault    = in_valid && (in_mem_read || in_mem_write) &&
                   ((in_addr[1:0] != 2'b00) ||
                    ((in_addr >> (ADDR_WIDTH + 2)) != '0) ||
                    (in_mem_read && in_mem_write));
        load_ok  = in_valid && in_mem_read && !fault;
        store_ok = in_valid && in_mem_write && !fault;
        mem_we   = store_ok && !reset;

        out_valid_d     = in_valid;
        out_rd_d        = in_rd;
        out_reg_wr_en_d = in_valid && in_reg_wr_en && !fault && (in_rd != 5'd0);
        pass_data_d     = fault ? '0 : in_addr;
        load_sel_d      = load_ok;
        mem_err_d       = fault;
        err_sticky_d    = err_sticky_q || fault;
        load_count_d    = load_count_q;
        store_count_d   = store_count_q;
        if (load_ok && load_count_q != 16'hFFFF) begin
            load_count_d = load_count_q + 16'd1;
        end
        if (store_ok && store_count_q != 16'hFFFF) begin
            store_count_d = store_count_q + 16'd1;
        end
    end

    // Registered read returns the pre-write word, matching read-first block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[index] <= in_store_data;
        end
        rd_data_q <= mem[index];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q     <= 1'b0;
            out_rd_q        <= 5'd0;
            out_reg_wr_en_q <= 1'b0;
            pass_data_q     <= '0;
            load_sel_q      <= 1'b0;
            mem_err_q       <= 1'b0;
            err_sticky_q    <= 1'b0;
            load_count_q    <= 16'd0;
            store_count_q   <= 16'd0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_rd_q        <= out_rd_d;
            out_reg_wr_en_q <= out_reg_wr_en_d;
            pass_data_q     <= pass_data_d;
            load_sel_q      <= load_sel_d;
            mem_err_q       <= mem_err_d;
            err_sticky_q    <= err_sticky_d;
            load_count_q    <= load_count_d;
            store_count_q   <= store_count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_rd        = out_rd_q;
    assign out_reg_wr_en = out_reg_wr_en_q;
    assign out_data      = load_sel_q ? rd_data_q : pass_data_q;
    assign mem_err       = mem_err_q;
    assign err_sticky    = err_sticky_q;
    assign load_count    = load_count_q;
    assign store_count   = store_count_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a reference model predicts each cycle's
// writeback, queues it, and compares it one edge later.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_addr;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_wr_en;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic        out_reg_wr_en;
    logic [31:0] out_data;
    logic        mem_err;
    logic        err_sticky;
    logic [15:0] load_count;
    logic [15:0] store_count;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_addr       (in_addr),
        .in_store_data (in_store_data),
        .in_rd         (in_rd),
        .in_reg_wr_en  (in_reg_wr_en),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .out_valid     (out_valid),
        .out_rd        (out_rd),
        .out_reg_wr_en (out_reg_wr_en),
        .out_data      (out_data),
        .mem_err       (mem_err),
        .err_sticky    (err_sticky),
        .load_count    (load_count),
        .store_count   (store_count)
    );

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        wr_en;
        logic [31:0] data;
        logic        err;
        logic        sticky;
        logic [15:0] lcnt;
        logic [15:0] scnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl_mem [256];
    logic        mdl_sticky;
    logic [15:0] mdl_lcnt;
    logic [15:0] mdl_scnt;
    int          checks = 0;
    int          errors = 0;
    bit          verbose = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic rd_req, input logic wr_req,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic wen, input string tag);
        exp_t        e;
        exp_t        g;
        logic        flt;
        logic [7:0]  idx;
        @(negedge clk);
        reset = rst; in_valid = v; in_mem_read = rd_req; in_mem_write = wr_req;
        in_addr = addr; in_store_data = sdata; in_rd = rd; in_reg_wr_en = wen;
        idx = addr[9:2];
        flt = v && (rd_req || wr_req) &&
              (addr[1:0] != 2'b00 || addr[31:10] != 22'd0 || (rd_req && wr_req));
        if (rst) begin
            e = '0;
            mdl_sticky = 1'b0; mdl_lcnt = 16'd0; mdl_scnt = 16'd0;
        end else begin
            e.valid = v;
            e.rd    = rd;
            e.wr_en = v && wen && !flt && (rd != 5'd0);
            e.data  = flt ? 32'd0 : ((v && rd_req) ? mdl_mem[idx] : addr);
            e.err   = flt;
            if (flt) mdl_sticky = 1'b1;
            if (v && rd_req && !flt && mdl_lcnt != 16'hFFFF) mdl_lcnt++;
            if (v && wr_req && !flt) begin
                mdl_mem[idx] = sdata;
                if (mdl_scnt != 16'hFFFF) mdl_scnt++;
            end
            e.sticky = mdl_sticky;
            e.lcnt   = mdl_lcnt;
            e.scnt   = mdl_scnt;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        check_eq({tag, ".valid"},  {31'd0, out_valid},     {31'd0, g.valid});
        check_eq({tag, ".rd"},     {27'd0, out_rd},        {27'd0, g.rd});
        check_eq({tag, ".wr_en"},  {31'd0, out_reg_wr_en}, {31'd0, g.wr_en});
        check_eq({tag, ".data"},   out_data,               g.data);
        check_eq({tag, ".err"},    {31'd0, mem_err},       {31'd0, g.err});
        check_eq({tag, ".sticky"}, {31'd0, err_sticky},    {31'd0, g.sticky});
        check_eq({tag, ".lcnt"},   {16'd0, load_count},    {16'd0, g.lcnt});
        check_eq({tag, ".scnt"},   {16'd0, store_count},   {16'd0, g.scnt});
        if (verbose)
            $display("txn %s: valid=%0b rd=%0d wr_en=%0b data=%h err=%0b sticky=%0b lc=%0d sc=%0d",
                     tag, out_valid, out_rd, out_reg_wr_en, out_data, mem_err, err_sticky,
                     load_count, store_count);
    endtask

    initial begin
        mdl_sticky = 1'b0; mdl_lcnt = 16'd0; mdl_scnt = 16'd0;
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_store_data = '0;
        in_rd = '0; in_reg_wr_en = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;

        step(1, 0, 0, 0, 32'h0,        32'h0,        5'd0, 0, "reset");
        step(1, 0, 0, 0, 32'h0,        32'h0,        5'd0, 0, "reset2");
        // store/load back-to-back forwarding through RAM
        step(0, 1, 0, 1, 32'h10,       32'hDEADBEEF, 5'd0, 0, "st10");
        step(0, 1, 1, 0, 32'h10,       32'h0,        5'd5, 1, "ld10");
        // ALU pass-through and rd=0 suppression
        step(0, 1, 0, 0, 32'h12345678, 32'h0,        5'd3, 1, "alu");
        step(0, 1, 0, 0, 32'hCAFEF00D, 32'h0,        5'd0, 1, "alu_rd0");
        step(0, 0, 1, 1, 32'h13,       32'h55,       5'd7, 1, "invalid");
        // faults: misaligned, out of range, read+write
        step(0, 1, 1, 0, 32'h13,       32'h0,        5'd6, 1, "ld_mis");
        step(0, 1, 0, 0, 32'h20,       32'h0,        5'd6, 1, "post_err");
        step(0, 1, 0, 1, 32'h0,        32'h11112222, 5'd0, 0, "st0");
        step(0, 1, 1, 0, 32'h400,      32'h0,        5'd4, 1, "ld_oor");
        step(0, 1, 0, 1, 32'h400,      32'h99999999, 5'd0, 0, "st_oor");
        step(0, 1, 1, 1, 32'h0,        32'h77777777, 5'd2, 1, "rw_both");
        step(0, 1, 1, 0, 32'h0,        32'h0,        5'd8, 1, "ld0");
        step(0, 1, 0, 1, 32'h3FC,      32'hA5A5A5A5, 5'd0, 0, "st_top");
        step(0, 1, 1, 0, 32'h3FC,      32'h0,        5'd9, 1, "ld_top");
        // reset during a store must not write RAM
        step(1, 1, 0, 1, 32'h10,       32'h0BADF00D, 5'd0, 0, "rst_st");
        step(0, 1, 1, 0, 32'h10,       32'h0,        5'd1, 1, "ld_after_rst");
        step(0, 1, 0, 1, 32'h44,       32'h0,        5'd0, 0, "st44");
        step(0, 1, 1, 0, 32'h44,       32'h0,        5'd1, 1, "ld44");
        // store counter saturation
        verbose = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            step(0, 1, 0, 1, {22'd0, 8'(i), 2'b00}, 32'(i), 5'd0, 0, "sat");
        end
        verbose = 1'b1;
        step(0, 1, 0, 0, 32'h1,        32'h0,        5'd2, 1, "sat_end");
        check_eq("sat_final", {16'd0, store_count}, 32'h0000FFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
